seq_add_wide: RTL
=================

# seq_add_wide

Multi-cycle wide adder/subtractor that splits an N×16-bit operand pair into 16-bit words. It streams the words, least-significant first, through one 16-bit carry-select adder slice, one word per cycle, and registers the carry between cycles. It sits directly upstream of the 16-bit adder: it owns operand sequencing, carry chaining and the valid/ready handshake, and it consumes `sum`/`cout` each cycle to build the wide result.

## Interface
- `NWORDS`, default 4: number of 16-bit words; operand width is 16·NWORDS. Legal range 2–16.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `in_valid` in 1: operand beat valid.
- `in_ready` out 1: block can accept an operand beat.
- `a` in 16·NWORDS: operand A.
- `b` in 16·NWORDS: operand B.
- `cin` in 1: carry-in. Ignored when `sub`=1.
- `sub` in 1: 0 computes A+B+cin; 1 computes A−B, i.e. A+~B+1.
- `out_valid` out 1: result valid.
- `out_ready` in 1: downstream accepts the result.
- `sum` out 16·NWORDS: wide result.
- `cout` out 1: carry out of the MSB. For subtraction, 1 means no borrow.
- `ovf` out 1: two's-complement signed overflow.
- `busy` out 1: high when state is not IDLE.

## Operation
- FSM with three states: IDLE, RUN, DONE.
- **IDLE**
  - `in_ready`=1.
  - On `in_valid`&`in_ready`, capture `a` and `b` into registers (B is stored inverted if `sub`=1).
  - Set carry register = `sub` ? 1 : `cin`, set idx=0, go to RUN.
- **RUN**
  - Each cycle, apply word[idx] of A and B with the carry register to the adder slice.
  - Write the slice `sum` into result word[idx] and its `cout` into the carry register; idx increments.
  - At idx = NWORDS−1, go to DONE after that word's update.
  - `in_ready`=0; `in_valid` is ignored.
- **DONE**
  - `out_valid`=1. `sum`, `cout`, `ovf` are stable.
  - On `out_valid`&`out_ready`, go to IDLE.
  - While `out_ready`=0, hold all outputs and keep `in_ready`=0.
- **Signed overflow:** computed on the final word: `ovf` = (A_msb == B'_msb) & (sum_msb != A_msb), where B' is B after optional inversion.
- **Width rule:** result is modulo 2^(16·NWORDS); the only extra bit is `cout`.
- **Reset** (any state, including mid-RUN): asynchronous return to IDLE.
  - Any partial result is discarded and no output beat is produced.
  - Reset values: `sum`=0, `cout`=0, `ovf`=0, `out_valid`=0, `busy`=0.
  - `in_ready` = (state==IDLE), so it reads 1 during reset, but inputs are ignored while `rst_n`=0.
- `sum`, `cout` and `ovf` are registered outputs; they change only on word writes or reset.

## Timing
- Accept edge T0: the beat is captured and the block enters RUN.
- Word k is added in cycle T0+1+k, and the result register updates at edge T0+1+k.
- `out_valid` rises after edge T0+NWORDS, i.e. NWORDS cycles after accept; 4 cycles for the default.
- If `out_ready`=1 in the first DONE cycle, the block is in IDLE on the next cycle.
- Minimum initiation interval is NWORDS+2 cycles.
- No combinational path from `in_valid` to `out_valid`, or from `out_ready` to `in_ready`.
- Adder slice path is a single cycle: slice sum/cout plus the carry register; no multicycle constraint.

## Structure
- Shared package holds:
  - `WORD_W`=16.
  - State enum {IDLE, RUN, DONE}.
  - idx width, $clog2(NWORDS).
- One sub-module: the existing 16-bit carry-select adder `CSA16ins`, instantiated once with ports a, b, cin, sum, cout.
- No second adder instance is permitted.
- Word select is an indexed part-select on the operand registers.

## Test plan
- **Carry across a word boundary:** NWORDS=4, A=0x0000_0000_0000_FFFF, B=0x1, cin=0, sub=0 → sum=0x0000_0000_0001_0000, cout=0, ovf=0; `out_valid` exactly 4 cycles after accept.
- **Full ripple:** A=0xFFFF_FFFF_FFFF_FFFF, B=0, cin=1 → sum=0, cout=1, ovf=0.
- **Subtract with borrow:** A=5, B=7, sub=1, cin=1 (must be ignored) → sum=0xFFFF_FFFF_FFFF_FFFE, cout=0, ovf=0.
- **Signed overflow:** A=0x7FFF_FFFF_FFFF_FFFF, B=1, sub=0 → sum=0x8000_0000_0000_0000, ovf=1, cout=0.
- **Backpressure:** `out_ready`=0 for 3 DONE cycles while `in_valid`=1 with new data → outputs held, `in_ready`=0, new beat not captured; raise `out_ready` → IDLE next cycle, `in_ready`=1, new beat accepted.
- **Reset mid-RUN:** assert `rst_n`=0 at idx=2 → same cycle `out_valid`=0, sum=0, `busy`=0; after release, no stale result appears and the next accepted beat gives the correct sum.

Source files
------------

// File: rtl/seq_add_wide_pkg.sv
// +--------------------------------------------------------------------------+
// | seq_add_wide_pkg : shared word width, FSM states and index sizing        |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

package seq_add_wide_pkg;

  localparam int WORD_W = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // A one-word index still needs a real bit, so never return zero.
  function automatic int idx_width(input int nwords);
    return (nwords > 1) ? $clog2(nwords) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/seq_add_wide_csa16.sv
// +--------------------------------------------------------------------------+
// | CSA16ins : 16-bit carry-select adder slice                               |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

module CSA16ins
  import seq_add_wide_pkg::*;
(
  input  logic [WORD_W-1:0] a,
  input  logic [WORD_W-1:0] b,
  input  logic              cin,
  output logic [WORD_W-1:0] sum,
  output logic              cout
);

  localparam int HALF = WORD_W / 2;

  logic [HALF:0] w_lo;
  logic [HALF:0] w_hi0;
  logic [HALF:0] w_hi1;

  assign w_lo  = {1'b0, a[HALF-1:0]} + {1'b0, b[HALF-1:0]} + {{HALF{1'b0}}, cin};

  // Upper half is computed for both possible carries; the low carry picks one.
  assign w_hi0 = {1'b0, a[WORD_W-1:HALF]} + {1'b0, b[WORD_W-1:HALF]};
  assign w_hi1 = {1'b0, a[WORD_W-1:HALF]} + {1'b0, b[WORD_W-1:HALF]} + {{HALF{1'b0}}, 1'b1};

  assign sum  = {(w_lo[HALF] ? w_hi1[HALF-1:0] : w_hi0[HALF-1:0]), w_lo[HALF-1:0]};
  assign cout = w_lo[HALF] ? w_hi1[HALF] : w_hi0[HALF];

endmodule

`default_nettype wire

// File: rtl/seq_add_wide.sv
// +--------------------------------------------------------------------------+
// | seq_add_wide : multi-cycle wide add/subtract through one 16-bit slice    |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

module seq_add_wide
  import seq_add_wide_pkg::*;
#(
  parameter int NWORDS = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WORD_W*NWORDS-1:0] a,
  input  logic [WORD_W*NWORDS-1:0] b,
  input  logic                     cin,
  input  logic                     sub,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WORD_W*NWORDS-1:0] sum,
  output logic                     cout,
  output logic                     ovf,
  output logic                     busy
);

  localparam int W   = WORD_W * NWORDS;
  localparam int IW  = idx_width(NWORDS);
  localparam int WSH = $clog2(WORD_W);
  localparam logic [IW-1:0] C_LAST = IW'(NWORDS - 1);

  state_t            r_state;
  logic [W-1:0]      r_a;
  logic [W-1:0]      r_b;
  logic [W-1:0]      r_sum;
  logic              r_carry;
  logic [IW-1:0]     r_idx;
  logic              r_cout;
  logic              r_ovf;
  logic              r_out_valid;
  logic              r_busy;

  logic [IW+WSH-1:0] w_base;
  logic [WORD_W-1:0] w_a_word;
  logic [WORD_W-1:0] w_b_word;
  logic [WORD_W-1:0] w_slice_sum;
  logic              w_slice_cout;
  logic              w_last;

  assign w_base   = {r_idx, {WSH{1'b0}}};
  assign w_a_word = r_a[w_base +: WORD_W];
  assign w_b_word = r_b[w_base +: WORD_W];
  assign w_last   = (r_idx == C_LAST);

  CSA16ins u_slice (
    .a    (w_a_word),
    .b    (w_b_word),
    .cin  (r_carry),
    .sum  (w_slice_sum),
    .cout (w_slice_cout)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_a         <= '0;
      r_b         <= '0;
      r_sum       <= '0;
      r_carry     <= 1'b0;
      r_idx       <= '0;
      r_cout      <= 1'b0;
      r_ovf       <= 1'b0;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (in_valid) begin
            // Subtraction is A + ~B + 1, so B is inverted once at capture.
            r_a     <= a;
            r_b     <= sub ? ~b : b;
            r_carry <= sub ? 1'b1 : cin;
            r_idx   <= '0;
            r_busy  <= 1'b1;
            r_state <= RUN;
          end
        end
        RUN: begin
          r_sum[w_base +: WORD_W] <= w_slice_sum;
          r_carry                 <= w_slice_cout;
          r_idx                   <= r_idx + 1'b1;
          if (w_last) begin
            r_cout      <= w_slice_cout;
            r_ovf       <= (w_a_word[WORD_W-1] == w_b_word[WORD_W-1]) &&
                           (w_slice_sum[WORD_W-1] != w_a_word[WORD_W-1]);
            r_out_valid <= 1'b1;
            r_state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_state     <= IDLE;
          end
        end
        default: begin
          r_out_valid <= 1'b0;
          r_busy      <= 1'b0;
          r_state     <= IDLE;
        end
      endcase
    end
  end

  assign in_ready  = (r_state == IDLE);
  assign out_valid = r_out_valid;
  assign busy      = r_busy;
  assign sum       = r_sum;
  assign cout      = r_cout;
  assign ovf       = r_ovf;

endmodule

`default_nettype wire
